// File: rtl/ttl_fetch_assembler_pkg.sv
// Shared definitions for the instruction-register fetch assembler.
package ttl_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_GAP    = 3'd2,
    ST_SETUP  = 3'd3,
    ST_STROBE = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // Cycles from the start sample to the done pulse with a zero-wait memory.
  function automatic int done_latency(input int bytes);
    return 2 * bytes + 2;
  endfunction

endpackage

// File: rtl/ttl_fetch_assembler_if.sv
// Byte-wide memory read bus with a req/ack handshake.
interface ttl_fetch_assembler_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_req;
  logic                  mem_ack;
  logic [7:0]            mem_data;

  modport master (output mem_addr, output mem_req, input mem_ack, input mem_data);
  modport slave  (input mem_addr, input mem_req, output mem_ack, output mem_data);
endinterface

// File: rtl/ttl_fetch_assembler_timeout_ctr.sv
// Saturating count of consecutive no-ack request cycles; TIMEOUT=0 never expires.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/ttl_fetch_assembler.sv
// Fetches BYTES little-endian bytes over the memory bus and strobes them into
// a pair of '273-style octal registers with a single clean clock edge.
module ttl_fetch_assembler
  import ttl_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int BYTES      = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  ttl_fetch_assembler_if.master mem,
  output logic [8*BYTES-1:0]    reg_d,
  output logic                  reg_clk,
  output logic                  reg_clr_n,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [IW-1:0]         idx;
  logic [8*BYTES-1:0]    buf_q, buf_n;
  logic                  ack_req, last_byte, expire;
  logic                  tmo_clr, tmo_inc;
  logic                  mem_req_c, busy_c, done_c;

  assign ack_req   = (state == ST_REQ) && mem.mem_ack;
  assign last_byte = (idx == LAST);
  assign tmo_clr   = (state != ST_REQ) || mem.mem_ack;
  assign tmo_inc   = (state == ST_REQ) && !mem.mem_ack;

  fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .inc    (tmo_inc),
    .expire (expire)
  );

  // Buffer with the byte arriving this cycle merged in, so the word can be
  // presented on reg_d as SETUP is entered.
  always_comb begin
    buf_n = buf_q;
    if (ack_req) begin
      buf_n[{idx, 3'b000} +: 8] = mem.mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    mem_req_c = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_n = ST_REQ;
      end
      ST_REQ: begin
        mem_req_c = 1'b1;
        busy_c    = 1'b1;
        // An ack on the expiring cycle still wins over the abort.
        if (mem.mem_ack) begin
          state_n = last_byte ? ST_SETUP : ST_GAP;
        end else if (expire) begin
          state_n = ST_ERR;
        end
      end
      ST_GAP: begin
        busy_c  = 1'b1;
        state_n = ST_REQ;
      end
      ST_SETUP: begin
        busy_c  = 1'b1;
        state_n = ST_STROBE;
      end
      ST_STROBE: begin
        busy_c  = 1'b1;
        state_n = ST_DONE;
      end
      ST_DONE: begin
        done_c  = 1'b1;
        state_n = ST_IDLE;
      end
      ST_ERR: begin
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign mem.mem_req  = mem_req_c;
  assign mem.mem_addr = addr_q;
  assign busy         = busy_c;
  assign done         = done_c;

  // reg_clk and reg_clr_n come straight from flops so the register pins
  // never see decode glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      idx         <= '0;
      buf_q       <= '0;
      reg_d       <= '0;
      reg_clk     <= 1'b0;
      reg_clr_n   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      reg_clk   <= (state_n == ST_STROBE);
      reg_clr_n <= (state_n != ST_ERR);
      buf_q     <= buf_n;
      if ((state == ST_IDLE) && start) begin
        addr_q      <= base_addr;
        idx         <= '0;
        timeout_err <= 1'b0;
      end
      if (state == ST_GAP) begin
        addr_q <= addr_q + 1'b1;
        idx    <= idx + 1'b1;
      end
      if (ack_req && last_byte) begin
        reg_d <= buf_n;
      end
      if (state_n == ST_ERR) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ttl_fetch_assembler.sv
// Bench for ttl_fetch_assembler: wait-state memory responder, '273 register
// model and a queue of expected fetched words.
module tb_ttl_fetch_assembler;
  localparam int AW  = 16;
  localparam int NB  = 2;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [15:0]   reg_d;
  logic          reg_clk, reg_clr_n, busy, done, timeout_err;

  ttl_fetch_assembler_if #(.ADDR_WIDTH(AW)) mem ();

  ttl_fetch_assembler #(.ADDR_WIDTH(AW), .BYTES(NB), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .mem         (mem),
    .reg_d       (reg_d),
    .reg_clk     (reg_clk),
    .reg_clr_n   (reg_clr_n),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem_model [0:65535];
  logic [15:0] exp_q [$];
  bit          resp_en = 1'b0;
  int          resp_waits = 0;

  // Memory responder: acks after resp_waits cycles of mem_req.
  initial begin
    int waited;
    waited = 0;
    mem.mem_ack  = 1'b0;
    mem.mem_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      mem.mem_ack = 1'b0;
      if (resp_en && mem.mem_req) begin
        if (waited >= resp_waits) begin
          mem.mem_ack  = 1'b1;
          mem.mem_data = mem_model[mem.mem_addr];
          waited = 0;
        end else begin
          waited++;
        end
      end else begin
        waited = 0;
      end
    end
  end

  // Downstream '273 pair: async clear, rising-edge load.
  logic [15:0] reg_q;
  int clk_rises = 0;
  always @(posedge reg_clk or negedge reg_clr_n) begin
    if (!reg_clr_n) reg_q <= 16'h0000;
    else            reg_q <= reg_d;
  end
  always @(posedge reg_clk) clk_rises++;

  logic [15:0] tr_addr [64];
  logic [15:0] tr_d    [64];
  logic        tr_req  [64];
  logic        tr_clk  [64];
  logic        tr_done [64];
  logic        tr_busy [64];
  logic        tr_err  [64];
  logic        tr_clrn [64];

  // Issues a start and records outputs for ncyc cycles; index k is the
  // k-th cycle after the start sample. start stays high until cycle hold.
  task automatic trace_fetch(input logic [15:0] base, input int ncyc, input int hold);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = base;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      if (k >= hold) start = 1'b0;
      tr_addr[k] = mem.mem_addr;
      tr_d[k]    = reg_d;
      tr_req[k]  = mem.mem_req;
      tr_clk[k]  = reg_clk;
      tr_done[k] = done;
      tr_busy[k] = busy;
      tr_err[k]  = timeout_err;
      tr_clrn[k] = reg_clr_n;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (reg_clr_n !== 1'b0) begin errors++; $display("FAIL rst_clr_n cyc%0d: got %b want 0", i, reg_clr_n); end
      checks++;
      if ({mem.mem_req, reg_clk, busy, done, timeout_err} !== 5'b0) begin
        errors++; $display("FAIL rst_ctrl cyc%0d: got %b want 00000", i, {mem.mem_req, reg_clk, busy, done, timeout_err});
      end
      checks++;
      if (reg_d !== 16'h0 || mem.mem_addr !== 16'h0) begin
        errors++; $display("FAIL rst_data cyc%0d: got d=%h a=%h want 0", i, reg_d, mem.mem_addr);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (reg_clr_n !== 1'b1) begin errors++; $display("FAIL rst_release_clr_n: got %b want 1", reg_clr_n); end
  endtask

  task automatic test_zero_wait();
    int dk, r0;
    logic [15:0] w;
    mem_model[16'h1000] = 8'h34;
    mem_model[16'h1001] = 8'h12;
    resp_en = 1'b1; resp_waits = 0;
    exp_q.push_back(16'h1234);
    r0 = clk_rises;
    trace_fetch(16'h1000, 8, 1);
    dk = 0;
    for (int k = 1; k <= 8; k++) if (tr_done[k] && dk == 0) dk = k;
    checks++;
    if (tr_addr[1] !== 16'h1000 || tr_req[1] !== 1'b1) begin errors++; $display("FAIL zw_addr0: got %h req=%b want 1000 req=1", tr_addr[1], tr_req[1]); end
    checks++;
    if (tr_req[2] !== 1'b0) begin errors++; $display("FAIL zw_gap_req: got %b want 0", tr_req[2]); end
    checks++;
    if (tr_addr[3] !== 16'h1001 || tr_req[3] !== 1'b1) begin errors++; $display("FAIL zw_addr1: got %h req=%b want 1001 req=1", tr_addr[3], tr_req[3]); end
    checks++;
    if (tr_d[4] !== 16'h1234 || tr_clk[4] !== 1'b0) begin errors++; $display("FAIL zw_setup: got d=%h clk=%b want 1234 clk=0", tr_d[4], tr_clk[4]); end
    checks++;
    if (tr_clk[5] !== 1'b1 || tr_clk[6] !== 1'b0) begin errors++; $display("FAIL zw_strobe: got %b%b want 10", tr_clk[5], tr_clk[6]); end
    checks++;
    if (dk != 6) begin errors++; $display("FAIL zw_latency: got %0d want 6", dk); end
    checks++;
    if (tr_busy[5] !== 1'b1 || tr_busy[6] !== 1'b0) begin errors++; $display("FAIL zw_busy: got %b%b want 10", tr_busy[5], tr_busy[6]); end
    checks++;
    if (clk_rises - r0 != 1) begin errors++; $display("FAIL zw_rises: got %0d want 1", clk_rises - r0); end
    checks++;
    if (dk == 0 || exp_q.size() == 0) begin
      errors++; $display("FAIL zw_word: no done within 8 cycles");
    end else begin
      w = exp_q.pop_front();
      if (reg_q !== w) begin errors++; $display("FAIL zw_word: got %h want %h", reg_q, w); end
    end
  endtask

  task automatic test_wait_wrap();
    int dk, r0, glitches;
    logic [15:0] w;
    mem_model[16'hFFFF] = 8'hCD;
    mem_model[16'h0000] = 8'hAB;
    resp_waits = 3;
    exp_q.push_back(16'hABCD);
    r0 = clk_rises;
    trace_fetch(16'hFFFF, 14, 1);
    dk = 0; glitches = 0;
    for (int k = 1; k <= 14; k++) begin
      if (tr_done[k] && dk == 0) dk = k;
      if (k < 11 && tr_clk[k] !== 1'b0) glitches++;
    end
    checks++;
    if (tr_addr[4] !== 16'hFFFF || tr_req[4] !== 1'b1) begin errors++; $display("FAIL ww_addr0: got %h req=%b want ffff req=1", tr_addr[4], tr_req[4]); end
    checks++;
    if (tr_addr[6] !== 16'h0000 || tr_req[6] !== 1'b1) begin errors++; $display("FAIL ww_wrap: got %h req=%b want 0000 req=1", tr_addr[6], tr_req[6]); end
    checks++;
    if (dk != 12) begin errors++; $display("FAIL ww_latency: got %0d want 12", dk); end
    checks++;
    if (glitches != 0 || tr_clk[11] !== 1'b1) begin errors++; $display("FAIL ww_strobe: got early=%0d strobe=%b want 0 1", glitches, tr_clk[11]); end
    checks++;
    if (clk_rises - r0 != 1) begin errors++; $display("FAIL ww_rises: got %0d want 1", clk_rises - r0); end
    checks++;
    if (dk == 0 || exp_q.size() == 0) begin
      errors++; $display("FAIL ww_word: no done within 14 cycles");
    end else begin
      w = exp_q.pop_front();
      if (reg_q !== w) begin errors++; $display("FAIL ww_word: got %h want %h", reg_q, w); end
    end
  endtask

  task automatic test_timeout();
    int ndone, r0;
    resp_en = 1'b0;
    r0 = clk_rises;
    trace_fetch(16'h4000, 10, 1);
    ndone = 0;
    for (int k = 1; k <= 10; k++) if (tr_done[k]) ndone++;
    checks++;
    if (tr_req[5] !== 1'b1 || tr_clrn[5] !== 1'b1) begin errors++; $display("FAIL to_waiting: got req=%b clr_n=%b want 1 1", tr_req[5], tr_clrn[5]); end
    checks++;
    if (tr_clrn[6] !== 1'b0 || tr_err[6] !== 1'b1 || tr_req[6] !== 1'b0 || tr_busy[6] !== 1'b0) begin
      errors++; $display("FAIL to_err_state: got clr_n=%b err=%b req=%b busy=%b want 0 1 0 0", tr_clrn[6], tr_err[6], tr_req[6], tr_busy[6]);
    end
    checks++;
    if (tr_clrn[7] !== 1'b1 || tr_err[7] !== 1'b1) begin errors++; $display("FAIL to_after: got clr_n=%b err=%b want 1 1", tr_clrn[7], tr_err[7]); end
    checks++;
    if (ndone != 0 || clk_rises != r0) begin errors++; $display("FAIL to_no_done: got done=%0d rises=%0d want 0 0", ndone, clk_rises - r0); end
    checks++;
    if (tr_d[6] !== 16'hABCD || reg_q !== 16'h0000) begin errors++; $display("FAIL to_regs: got d=%h q=%h want abcd 0000", tr_d[6], reg_q); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
  endtask

  task automatic test_ack_boundary();
    int dk, ndone, nerr;
    logic [15:0] w;
    mem_model[16'h3000] = 8'h5A;
    mem_model[16'h3001] = 8'hA5;
    resp_en = 1'b1; resp_waits = TMO;
    exp_q.push_back(16'hA55A);
    trace_fetch(16'h3000, 20, 8);
    dk = 0; ndone = 0; nerr = 0;
    for (int k = 1; k <= 20; k++) begin
      if (tr_done[k]) begin ndone++; if (dk == 0) dk = k; end
      if (tr_err[k] !== 1'b0) nerr++;
    end
    checks++;
    if (nerr != 0) begin errors++; $display("FAIL ab_err: got %0d cycles with timeout_err want 0", nerr); end
    checks++;
    if (dk != 14 || ndone != 1) begin errors++; $display("FAIL ab_done: got at=%0d count=%0d want 14 1", dk, ndone); end
    checks++;
    if (dk == 0 || exp_q.size() == 0) begin
      errors++; $display("FAIL ab_word: no done within 20 cycles");
    end else begin
      w = exp_q.pop_front();
      if (reg_q !== w) begin errors++; $display("FAIL ab_word: got %h want %h", reg_q, w); end
    end
  endtask

  task automatic test_reset_mid_fetch();
    int r0, dk;
    logic [15:0] w;
    mem_model[16'h2000] = 8'h11;
    mem_model[16'h2001] = 8'h22;
    resp_waits = 3;
    r0 = clk_rises;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h2000;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    checks++;
    if (mem.mem_req !== 1'b1 || mem.mem_addr !== 16'h2001) begin errors++; $display("FAIL rm_second_req: got req=%b a=%h want 1 2001", mem.mem_req, mem.mem_addr); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({mem.mem_req, busy, reg_clk, reg_clr_n} !== 4'b0 || reg_d !== 16'h0) begin
      errors++; $display("FAIL rm_abort: got req/busy/clk/clr_n=%b d=%h want 0000 0000", {mem.mem_req, busy, reg_clk, reg_clr_n}, reg_d);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (clk_rises != r0 || reg_q !== 16'h0 || reg_clr_n !== 1'b1) begin
      errors++; $display("FAIL rm_after: got rises=%0d q=%h clr_n=%b want 0 0000 1", clk_rises - r0, reg_q, reg_clr_n);
    end
    resp_waits = 0;
    exp_q.push_back(16'h2211);
    trace_fetch(16'h2000, 8, 1);
    dk = 0;
    for (int k = 1; k <= 8; k++) if (tr_done[k] && dk == 0) dk = k;
    checks++;
    if (dk != 6) begin errors++; $display("FAIL rm_refetch_latency: got %0d want 6", dk); end
    checks++;
    if (dk == 0 || exp_q.size() == 0) begin
      errors++; $display("FAIL rm_refetch_word: no done within 8 cycles");
    end else begin
      w = exp_q.pop_front();
      if (reg_q !== w) begin errors++; $display("FAIL rm_refetch_word: got %h want %h", reg_q, w); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_wrap();
    test_timeout();
    test_ack_boundary();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
